// File: rtl/sym_fir_fold_stage_if.sv
// Handshake bundle for the symmetric FIR fold stage: sample in, folded pair sums out.
// Optional SYM_FOLD_SAT_EN adds the registered sat_flag alongside sum_out.
interface sym_fir_fold_stage_if #(
  parameter int WIDTH = 24,
  parameter int TAP   = 101
);
  localparam int NPAIR = (TAP + 1) / 2;
  localparam int CW    = $clog2(TAP + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic signed [WIDTH-1:0]       sample_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [NPAIR*(WIDTH+1)-1:0]    sum_out;
  logic [CW-1:0]                 fill_cnt;
`ifdef SYM_FOLD_SAT_EN
  logic                          sat_flag;

  modport slave  (input  in_valid, sample_in, out_ready,
                  output in_ready, out_valid, sum_out, fill_cnt, sat_flag);
  modport master (output in_valid, sample_in, out_ready,
                  input  in_ready, out_valid, sum_out, fill_cnt, sat_flag);
`else
  modport slave  (input  in_valid, sample_in, out_ready,
                  output in_ready, out_valid, sum_out, fill_cnt);
  modport master (output in_valid, sample_in, out_ready,
                  input  in_ready, out_valid, sum_out, fill_cnt);
`endif
endinterface

// File: rtl/sym_fir_fold_stage.sv
// Symmetric FIR fold stage: TAP-deep delay line with registered pair sums d[i]+d[TAP-1-i].
// Define SYM_FOLD_SAT_EN to clip each lane to the WIDTH range and report clipping on sat_flag.
module sym_fir_fold_stage #(
  parameter int WIDTH     = 24,
  parameter int TAP       = 101,
  parameter int GATE_FILL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  sym_fir_fold_stage_if.slave bus
);
  localparam int NPAIR = (TAP + 1) / 2;
  localparam int NHALF = TAP / 2;
  localparam int SW    = WIDTH + 1;
  localparam int CW    = $clog2(TAP + 1);

  function automatic logic signed [SW-1:0] ext(input logic signed [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction

`ifdef SYM_FOLD_SAT_EN
  function automatic logic ovf(input logic signed [SW-1:0] s);
    return s[SW-1] != s[SW-2];
  endfunction

  function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] s);
    if (ovf(s)) return {s[SW-1], s[SW-1], {(WIDTH-1){~s[SW-1]}}};
    return s;
  endfunction
`endif

  logic signed [WIDTH-1:0] dly_p0 [TAP];
  logic signed [WIDTH-1:0] view   [TAP];
  logic signed [SW-1:0]    pair;
  logic [NPAIR*SW-1:0]     sum_nxt;
  logic [NPAIR*SW-1:0]     sum_p1;
  logic                    vld_p1;
  logic [CW-1:0]           fill_p1;
  logic [CW-1:0]           fill_nxt;
  logic                    accept;
`ifdef SYM_FOLD_SAT_EN
  logic                    clip_nxt;
  logic                    sat_p1;
`endif

  assign bus.in_ready  = !vld_p1 || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.sum_out   = sum_p1;
  assign bus.fill_cnt  = fill_p1;
`ifdef SYM_FOLD_SAT_EN
  assign bus.sat_flag  = sat_p1;
`endif

  assign fill_nxt = (fill_p1 == CW'(TAP)) ? fill_p1 : fill_p1 + CW'(1);

  // Sums are formed from the line as it will look after this sample shifts in.
  always_comb begin
    view[0] = bus.sample_in;
    for (int k = 1; k < TAP; k++) view[k] = dly_p0[k-1];
  end

  always_comb begin
    sum_nxt = '0;
    pair    = '0;
`ifdef SYM_FOLD_SAT_EN
    clip_nxt = 1'b0;
`endif
    for (int i = 0; i < NHALF; i++) begin
      pair = ext(view[i]) + ext(view[TAP-1-i]);
`ifdef SYM_FOLD_SAT_EN
      if (ovf(pair)) clip_nxt = 1'b1;
      sum_nxt[i*SW +: SW] = sat(pair);
`else
      sum_nxt[i*SW +: SW] = pair;
`endif
    end
    // Odd TAP: the last lane carries the lone centre sample, not doubled.
    if (TAP % 2 == 1) sum_nxt[(NPAIR-1)*SW +: SW] = ext(view[NHALF]);
  end

  // ---- stage p0 (delay line) -> p1 (registered sums) ----
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int k = 0; k < TAP; k++) dly_p0[k] <= '0;
      sum_p1  <= '0;
      vld_p1  <= 1'b0;
      fill_p1 <= '0;
`ifdef SYM_FOLD_SAT_EN
      sat_p1  <= 1'b0;
`endif
    end else if (accept) begin
      dly_p0[0] <= bus.sample_in;
      for (int k = 1; k < TAP; k++) dly_p0[k] <= dly_p0[k-1];
      sum_p1  <= sum_nxt;
      fill_p1 <= fill_nxt;
      vld_p1  <= (GATE_FILL == 0) || (fill_nxt == CW'(TAP));
`ifdef SYM_FOLD_SAT_EN
      sat_p1  <= clip_nxt;
`endif
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sym_fir_fold_stage.sv
// Scoreboard bench for sym_fir_fold_stage: three configurations (odd, even, two-tap ungated).
// Expected lane sums are hand-computed; monitors pop them as outputs transfer.
module tb_sym_fir_fold_stage;
  logic clk = 1'b0;
  logic rst;
  logic clr_a, clr_b, clr_c;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] qc[$];
  int tbl_b[5] = '{10, -3, 7, -20, 100};

  always #5 clk = ~clk;

  sym_fir_fold_stage_if #(.WIDTH(8), .TAP(5)) ifa ();
  sym_fir_fold_stage_if #(.WIDTH(8), .TAP(4)) ifb ();
  sym_fir_fold_stage_if #(.WIDTH(8), .TAP(2)) ifc ();

  sym_fir_fold_stage #(.WIDTH(8), .TAP(5), .GATE_FILL(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clr_a), .bus(ifa.slave));
  sym_fir_fold_stage #(.WIDTH(8), .TAP(4), .GATE_FILL(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clr_b), .bus(ifb.slave));
  sym_fir_fold_stage #(.WIDTH(8), .TAP(2), .GATE_FILL(0)) dut_c (
    .clk(clk), .rst(rst), .clear(clr_c), .bus(ifc.slave));

  function automatic logic [26:0] pk3(input int l0, input int l1, input int l2);
    return {9'(l2), 9'(l1), 9'(l0)};
  endfunction

  function automatic logic [17:0] pk2(input int l0, input int l1);
    return {9'(l1), 9'(l0)};
  endfunction

  function automatic logic [9:0] pkc(input logic s, input int l0);
    return {s, 9'(l0)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output transfer with empty scoreboard", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare on every output transfer (out_valid && out_ready).
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) begin
      if (qa.size() == 0) unexpected("a_out");
      else check("a_out", 64'(ifa.sum_out), qa.pop_front());
    end
    if (ifb.out_valid && ifb.out_ready) begin
      if (qb.size() == 0) unexpected("b_out");
      else check("b_out", 64'(ifb.sum_out), qb.pop_front());
    end
    if (ifc.out_valid && ifc.out_ready) begin
      if (qc.size() == 0) unexpected("c_out");
`ifdef SYM_FOLD_SAT_EN
      else check("c_out", 64'({ifc.sat_flag, ifc.sum_out}), qc.pop_front());
`else
      else check("c_out", 64'({1'b0, ifc.sum_out}), qc.pop_front());
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.sample_in = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.sample_in = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.sample_in = '0; ifc.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("a_rst_vld",  64'(ifa.out_valid), 64'd0);
    check("a_rst_fill", 64'(ifa.fill_cnt),  64'd0);
    check("a_rst_sum",  64'(ifa.sum_out),   64'd0);
    check("a_rst_rdy",  64'(ifa.in_ready),  64'd1);
    check("c_rst_fill", 64'(ifc.fill_cnt),  64'd0);

    // Odd fold, gated fill
    for (int v = 1; v <= 5; v++) begin
      ifa.in_valid  = 1'b1;
      ifa.sample_in = 8'(v);
      if (v == 5) qa.push_back(64'(pk3(6, 6, 3)));
      tick();
      check("a_fill_cnt", 64'(ifa.fill_cnt), 64'(v));
      check("a_fill_vld", 64'(ifa.out_valid), 64'(v == 5));
    end
    check("a_fold", 64'(ifa.sum_out), 64'(pk3(6, 6, 3)));

    // Backpressure: 9 waits until out_ready rises
    ifa.sample_in = 8'd9;
    repeat (3) begin
      check("a_bp_rdy", 64'(ifa.in_ready), 64'd0);
      tick();
      check("a_bp_hold", 64'(ifa.sum_out), 64'(pk3(6, 6, 3)));
      check("a_bp_fill", 64'(ifa.fill_cnt), 64'd5);
    end
    ifa.out_ready = 1'b1;
    qa.push_back(64'(pk3(11, 8, 4)));
    tick();
    ifa.in_valid = 1'b0;
    check("a_bp_next", 64'(ifa.sum_out), 64'(pk3(11, 8, 4)));
    check("a_bp_vld",  64'(ifa.out_valid), 64'd1);
    tick();
    check("a_drain_vld", 64'(ifa.out_valid), 64'd0);

    // Even fold
    for (int i = 0; i < 5; i++) begin
      ifb.in_valid  = 1'b1;
      ifb.sample_in = 8'(tbl_b[i]);
      if (i == 3) qb.push_back(64'(pk2(-10, 4)));
      if (i == 4) qb.push_back(64'(pk2(97, -13)));
      tick();
    end
    ifb.in_valid = 1'b0;
    check("b_fill_sat", 64'(ifb.fill_cnt), 64'd4);
    tick();

    // Width extremes, two-tap ungated
`ifdef SYM_FOLD_SAT_EN
    qc.push_back(64'(pkc(1'b0, 127)));
    qc.push_back(64'(pkc(1'b1, 127)));
    qc.push_back(64'(pkc(1'b0, -1)));
    qc.push_back(64'(pkc(1'b1, -128)));
`else
    qc.push_back(64'(pkc(1'b0, 127)));
    qc.push_back(64'(pkc(1'b0, 254)));
    qc.push_back(64'(pkc(1'b0, -1)));
    qc.push_back(64'(pkc(1'b0, -256)));
`endif
    ifc.in_valid = 1'b1;
    ifc.sample_in = 8'sd127;  tick();
    ifc.sample_in = 8'sd127;  tick();
    ifc.sample_in = -8'sd128; tick();
    ifc.sample_in = -8'sd128; tick();

    // Clear wins over a concurrent accept of 50
    ifc.sample_in = 8'sd50;
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    check("c_clr_fill", 64'(ifc.fill_cnt),  64'd0);
    check("c_clr_vld",  64'(ifc.out_valid), 64'd0);
    qc.push_back(64'(pkc(1'b0, 50)));
    qc.push_back(64'(pkc(1'b0, 110)));
    qc.push_back(64'(pkc(1'b0, 90)));
    ifc.sample_in = 8'sd50; tick();
    ifc.sample_in = 8'sd60; tick();
    ifc.sample_in = 8'sd30; tick();
    ifc.in_valid = 1'b0;
    check("c_fill_sat", 64'(ifc.fill_cnt), 64'd2);
    tick();

    // Reset during a stall discards the held output
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.sample_in = 8'd1;
    tick();
    ifa.in_valid = 1'b0;
    check("a_stall_vld", 64'(ifa.out_valid), 64'd1);
    check("a_stall_sum", 64'(ifa.sum_out), 64'(pk3(4, 13, 5)));
    check("a_stall_rdy", 64'(ifa.in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("a_mrst_vld",  64'(ifa.out_valid), 64'd0);
    check("a_mrst_sum",  64'(ifa.sum_out),   64'd0);
    check("a_mrst_rdy",  64'(ifa.in_ready),  64'd1);
    check("a_mrst_fill", 64'(ifa.fill_cnt),  64'd0);
    tick();

    check("qa_drained", 64'(qa.size()), 64'd0);
    check("qb_drained", 64'(qb.size()), 64'd0);
    check("qc_drained", 64'(qc.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
